// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with two-entry skid buffer, flush-to-NOP and saturating stall counter.
// Latency: one cycle from acceptance to out_data; out_valid/in_ready come from state flops only.
// Backpressure: absorbs one extra payload into skid after out_ready drops, then deasserts in_ready.
module pipe_skid_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] NOP_VAL = WIDTH'(32'h0000_0013),
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;

    // Handshake outputs decode from state only, so no input reaches them combinationally.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_FULL);
    assign out_data  = main_q;
    assign stall_cnt = stall_cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    main_d  = NOP_VAL;
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: begin
                main_d  = NOP_VAL;
                state_d = ST_EMPTY;
            end
        endcase

        // Flush wins over every handshake; an accepted input this cycle is dropped too.
        if (flush) begin
            main_d  = NOP_VAL;
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= NOP_VAL;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg (CNT_W=4): directed scenarios plus a random handshake phase.
module tb_pipe_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  stall_cnt;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] sb[$];
    logic [3:0]  exp_stall;

    pipe_skid_reg #(.WIDTH(32), .NOP_VAL(32'h0000_0013), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called one time unit after a rising edge with inputs already driven.
    task automatic step();
        logic [31:0] exp_d;
        if (out_valid && !out_ready && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) check_val("sb_underflow", 32'd1, 32'd0);
            else begin
                exp_d = sb.pop_front();
                check_val("out_data", out_data, exp_d);
            end
        end
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(in_data);
        @(posedge clk);
        #1;
        check_val("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check_val("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        check_val("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        if (sb.size() == 0) check_val("empty_nop", out_data, NOP);
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        exp_stall = 4'd0;
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check_val({tag, "_out_data"}, out_data, NOP);
        check_val({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        exp_stall = 4'd0;
        #3;
        check_val("por_out_valid", 32'(out_valid), 32'd0);
        check_val("por_in_ready", 32'(in_ready), 32'd1);
        check_val("por_out_data", out_data, NOP);
        check_val("por_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill to FULL, then reset asynchronously between edges.
        in_valid = 1'b1; in_data = 32'hAAAA_0001; step();
        in_data = 32'hAAAA_0002; step();
        in_valid = 1'b0;
        check_val("full_main", out_data, 32'hAAAA_0001);
        check_val("full_in_ready", 32'(in_ready), 32'd0);
        async_reset_check("rst_full");

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = 32'(i); step();
            check_val("stream_lat", out_data, 32'(i));
            check_val("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0; step();
        check_val("stream_stall", 32'(stall_cnt), 32'd0);

        // Skid: 0x11 arrives while out_ready is low.
        in_valid = 1'b1; in_data = 32'h10; step();
        out_ready = 1'b0; in_data = 32'h11; step();
        check_val("skid_in_ready", 32'(in_ready), 32'd0);
        check_val("skid_main", out_data, 32'h10);
        in_valid = 1'b0; out_ready = 1'b1; step();
        check_val("skid_recover", 32'(in_ready), 32'd1);
        check_val("skid_second", out_data, 32'h11);
        step();

        // Flush while FULL.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h20; step();
        in_data = 32'h21; step();
        in_valid = 1'b0; flush = 1'b1; step();
        flush = 1'b0;
        check_val("fl_out_valid", 32'(out_valid), 32'd0);
        check_val("fl_out_data", out_data, NOP);
        check_val("fl_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1; step(); step();

        // Flush with concurrent acceptance.
        in_valid = 1'b1; in_data = 32'h30; flush = 1'b1; step();
        in_valid = 1'b0; flush = 1'b0;
        check_val("fl30_out_valid", 32'(out_valid), 32'd0);
        step();
        check_val("fl30_gone", out_data, NOP);

        // Random handshakes with occasional flush.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = 32'h1000 + 32'(i);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        // Stall counter saturation.
        async_reset_check("rst_pre_stall");
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h40; step();
        in_valid = 1'b0;
        repeat (20) step();
        check_val("stall_sat", 32'(stall_cnt), 32'd15);
        flush = 1'b1; step();
        flush = 1'b0;
        check_val("stall_after_flush", 32'(stall_cnt), 32'd15);
        async_reset_check("rst_stall");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline buffer register that replaces the fixed, always-advancing stage registers between IF/ID/EX/MEM/WB. It carries an arbitrary-width packed stage payload with a valid/ready handshake. A two-entry skid buffer keeps both valid and ready fully registered, so a stall never creates a combinational path across the stage. It also supports synchronous flush to a NOP payload and a saturating stall-cycle counter for performance debug.

## Interface
- WIDTH, 32, payload width in bits (width of the packed stage struct)
- NOP_VAL, 32'h0000_0013, value driven on out_data when the stage is empty; RISC-V `addi x0,x0,0`; WIDTH bits
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous flush; kills both entries
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept; registered
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  downstream payload valid; registered
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  downstream payload; registered
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

## Operation
- Storage:
  - main register, which drives out_data.
  - skid register, which holds one overflow entry.
- States:
  - EMPTY: main is invalid. out_valid=0, in_ready=1.
  - BUSY: main is valid, skid is empty. out_valid=1, in_ready=1.
  - FULL: both entries are valid. out_valid=1, in_ready=0.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: if in_fire, main<=in_data, go to BUSY. Otherwise stay.
  - BUSY, in_fire & out_fire: main<=in_data, stay BUSY.
  - BUSY, in_fire only: skid<=in_data, go to FULL.
  - BUSY, out_fire only: main<=NOP_VAL, go to EMPTY.
  - BUSY, neither: hold.
  - FULL: if out_fire, main<=skid, go to BUSY. Otherwise hold. in_fire is impossible in FULL.
- Flush:
  - flush=1 has priority over every event in that cycle.
  - Next state is EMPTY, main<=NOP_VAL, skid is discarded.
  - Any concurrent in_fire is dropped, including the one accepted that cycle.
  - An out_fire in the same cycle still counts as consumed downstream.
- Ordering: payloads leave in acceptance order. No payload is ever duplicated or lost, except by flush.
- stall_cnt:
  - Increments by 1 in every cycle where out_valid=1 and out_ready=0.
  - Holds at 2^CNT_W-1 (saturates, no wrap).
  - Cleared only by reset; flush does not clear it.
- in_ready and out_valid are decoded from state flops only. No combinational path from out_ready or in_valid to any output.

## Timing
- Reset values while reset=1 and after release:
  - state EMPTY
  - out_valid=0
  - in_ready=1
  - out_data=NOP_VAL
  - skid contents don't-care
  - stall_cnt=0
- Reset asserted mid-operation: all state is lost immediately (asynchronously). The first edge after release behaves as EMPTY.
- Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N; one cycle.
- Throughput: one payload per cycle while out_ready=1 continuously.
- Backpressure: after out_ready drops, the stage absorbs one extra payload into skid. in_ready falls one cycle after out_ready falls, if a payload arrived meanwhile.
- Recovery: from FULL, in_ready rises the cycle after the first out_fire.
- Flush: out_valid=0 and in_ready=1 from the edge after flush=1.

## Test plan
- Reset: assert reset asynchronously mid-FULL, with out_data=32'hAAAA_0001 and skid=32'hAAAA_0002.
  - Immediately: out_valid=0, in_ready=1, out_data=32'h0000_0013, stall_cnt=0.
- Streaming: out_ready=1, send 32'h1, 32'h2, 32'h3 on consecutive cycles.
  - Output: 1, 2, 3 on consecutive cycles, each one cycle after acceptance.
  - in_ready stays 1 and stall_cnt stays 0.
- Skid: send 32'h10 and 32'h11 back-to-back, drop out_ready in the cycle 32'h10 is presented.
  - 32'h11 lands in skid, in_ready=0 next cycle.
  - Raise out_ready: output 10 then 11, no loss. in_ready=1 one cycle after the first out_fire.
- Flush in FULL, with 32'h20 in main and 32'h21 in skid:
  - next cycle out_valid=0, out_data=32'h13, in_ready=1.
  - 32'h20 and 32'h21 never appear on the output.
- Flush with concurrent in_fire of 32'h30: 32'h30 is dropped and the stage is EMPTY next cycle.
- Stall counter, CNT_W=4:
  - Hold out_valid=1, out_ready=0 for 20 cycles: stall_cnt reaches 15 and stays at 15.
  - flush: stall_cnt stays 15. reset: stall_cnt=0.
